// File: rtl/nukv_afull_pkg.sv
// Shared types for the almost-full aware issuing stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nukv_afull_pkg;

    // Issue state: FLOW launches words into the output slice, HOLD freezes launching.
    typedef enum logic {
        FLOW = 1'b0,
        HOLD = 1'b1
    } afs_state_t;

    // Width of the exported statistics counters.
    localparam int STAT_W = 32;

endpackage

// File: rtl/nukv_afull_sbuf.sv
// Small synchronous FIFO holding words between the upstream handshake and the output slice.
// Latency: a written word becomes visible at the read port one edge after it is written.
// Backpressure: full_next reports occupancy after the current edge; caller must not write when full.
//
// Ports: clk/rst (async active-high), wr_en/wr_data write side, rd_en/rd_data read side
// (rd_data is the current head), empty (no visible word), full_next (full after this edge).
module nukv_afull_sbuf #(
    parameter int DATA_SIZE     = 16,
    parameter int BUF_ADDR_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 empty,
    output logic                 full_next
);

    localparam int DEPTH = 1 << BUF_ADDR_BITS;
    localparam int PTR_W = BUF_ADDR_BITS + 1;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    // Write pointer as seen by the read side. It trails wr_ptr by one edge, so a
    // word written at edge N is first readable in the cycle after edge N+1; there
    // is no write-to-read bypass.
    logic [PTR_W-1:0] wr_ptr_vis;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;

    assign wr_ptr_nxt = wr_ptr + PTR_W'(wr_en);
    assign rd_ptr_nxt = rd_ptr + PTR_W'(rd_en);

    assign full_next = (wr_ptr_nxt[BUF_ADDR_BITS] != rd_ptr_nxt[BUF_ADDR_BITS]) &&
                       (wr_ptr_nxt[BUF_ADDR_BITS-1:0] == rd_ptr_nxt[BUF_ADDR_BITS-1:0]);

    assign empty   = (wr_ptr_vis == rd_ptr);
    assign rd_data = mem[rd_ptr[BUF_ADDR_BITS-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_ptr_vis <= '0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            wr_ptr_vis <= wr_ptr;
        end
    end

    // Storage needs no reset: pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[BUF_ADDR_BITS-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/nukv_afull_sender.sv
// Issuing stage that buffers upstream words and stops launching them while downstream is almost full.
// Latency: upstream handshake at edge N -> word valid on m_axis after edge N+2 (empty stage, FLOW).
// Backpressure: s_axis_tready is registered buffer-not-full; launching pauses on registered almost-full
//               and resumes after RESUME_CYCLES consecutive low cycles.
//
// Ports: clk/rst (async active-high); s_axis_* upstream stream; m_axis_* registered downstream
// slice plus m_axis_talmostfull; stat_words_out (downstream handshakes, wraps) and
// stat_stall_cycles (stalled cycles with pending data, saturates).
module nukv_afull_sender
    import nukv_afull_pkg::*;
#(
    parameter int DATA_SIZE     = 16,
    parameter int BUF_ADDR_BITS = 2,
    parameter int RESUME_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [DATA_SIZE-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    input  logic                 m_axis_talmostfull,
    output logic [STAT_W-1:0]    stat_words_out,
    output logic [STAT_W-1:0]    stat_stall_cycles
);

    localparam int CNT_W = (RESUME_CYCLES < 1) ? 1 : $clog2(RESUME_CYCLES + 1);

    afs_state_t           state;
    logic [CNT_W-1:0]     resume_cnt;
    logic [CNT_W-1:0]     resume_cnt_inc;
    logic                 af_q;

    logic                 buf_wr;
    logic                 buf_rd;
    logic                 buf_empty;
    logic                 buf_full_next;
    logic [DATA_SIZE-1:0] buf_head;

    logic                 slice_load;
    logic                 out_hs;
    logic                 stall_cycle;

    assign buf_wr = s_axis_tvalid && s_axis_tready;

    // Launch only in FLOW and only while the registered almost-full is low, so the
    // FLOW cycle that first sees af_q already refrains from loading.
    assign slice_load = (!m_axis_tvalid || m_axis_tready) && !buf_empty &&
                        (state == FLOW) && !af_q;
    assign buf_rd     = slice_load;
    assign out_hs     = m_axis_tvalid && m_axis_tready;

    // A stalled cycle is any cycle in which launching is suppressed by almost-full
    // (HOLD, or the FLOW cycle that is switching to HOLD) while data is waiting.
    assign stall_cycle = ((state == HOLD) || af_q) && (!buf_empty || m_axis_tvalid);

    assign resume_cnt_inc = resume_cnt + CNT_W'(1);

    nukv_afull_sbuf #(
        .DATA_SIZE     (DATA_SIZE),
        .BUF_ADDR_BITS (BUF_ADDR_BITS)
    ) u_sbuf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (buf_wr),
        .wr_data   (s_axis_tdata),
        .rd_en     (buf_rd),
        .rd_data   (buf_head),
        .empty     (buf_empty),
        .full_next (buf_full_next)
    );

    // Ready is registered from next-state occupancy: no input reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axis_tready <= 1'b0;
            af_q          <= 1'b0;
        end else begin
            s_axis_tready <= !buf_full_next;
            af_q          <= m_axis_talmostfull;
        end
    end

    // Output slice: data and valid stay put until accepted, in either state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (slice_load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= buf_head;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Issue FSM with hysteresis counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FLOW;
            resume_cnt <= '0;
        end else begin
            case (state)
                FLOW: begin
                    if (af_q) begin
                        state      <= HOLD;
                        resume_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (af_q) begin
                        resume_cnt <= '0;
                    end else if (resume_cnt_inc == CNT_W'(RESUME_CYCLES)) begin
                        state      <= FLOW;
                        resume_cnt <= '0;
                    end else begin
                        resume_cnt <= resume_cnt_inc;
                    end
                end
                default: begin
                    state      <= FLOW;
                    resume_cnt <= '0;
                end
            endcase
        end
    end

    // Statistics: words out wraps, stall cycles saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_words_out    <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (out_hs) begin
                stat_words_out <= stat_words_out + STAT_W'(1);
            end
            if (stall_cycle && (stat_stall_cycles != '1)) begin
                stat_stall_cycles <= stat_stall_cycles + STAT_W'(1);
            end
        end
    end

endmodule
